// File: rtl/cart_pkg.sv
// Shared types and the cart LED mask decoder for the player row.
// No state; the mask function is pure combinational decode.
// No handshake; callers slice the result to their row width.
package cart_pkg;

    typedef enum logic {PLAY = 1'b0, DEAD = 1'b1} cart_state_t;

    localparam int MAX_COLS  = 32;
    localparam int MAX_IDX_W = 5;

    // Bits above cols stay zero so the result can be sliced to any row width.
    function automatic logic [MAX_COLS-1:0] cart_mask(input int pos, input int cols,
                                                      input int cart_w, input bit wrap);
        logic [MAX_COLS-1:0] m;
        int                  idx;
        m = '0;
        for (int k = 0; k < MAX_COLS; k++) begin
            if (k < cart_w) begin
                idx = pos + k;
                if (wrap && idx >= cols)
                    idx = idx - cols;
                if (idx < cols)
                    m[idx[MAX_IDX_W-1:0]] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cart_row_if.sv
// Button/game-over inputs and row/position/alive outputs of one cart row.
// Latency and flow control are defined by the attached cart_row instance.
// No backpressure; inputs are levels sampled every clock.
interface cart_row_if #(parameter int COLS = 8);

    localparam int PW = $clog2(COLS);

    logic            inL;
    logic            inR;
    logic            gg;
    logic [COLS-1:0] out;
    logic [PW-1:0]   pos;
    logic            alive;

    modport master (output inL, inR, gg, input  out, pos, alive);
    modport slave  (input  inL, inR, gg, output out, pos, alive);

endinterface

// File: rtl/tick_div.sv
// Free-running sample divider: tick is high while the count is zero.
// Tick is decoded from the counter register, no input-to-output path.
// No backpressure; en freezes the count, clr forces it to zero.
module tick_div #(
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/cart_row.sv
// Player-row cart: latches button presses and moves the cart one column per tick.
// New position is visible on out/pos one clock after the tick edge.
// No backpressure; presses between ticks are held in sticky request latches.
module cart_row
    import cart_pkg::*;
#(
    parameter int COLS      = 8,
    parameter int CART_W    = 2,
    parameter int WIDTH     = 2,
    parameter int WRAP      = 1,
    parameter int START_POS = (COLS - CART_W) / 2
) (
    input  logic       clk,
    input  logic       reset,
    cart_row_if.slave  bus
);

    localparam int              PW      = $clog2(COLS);
    localparam int              LIMIT   = (WRAP != 0) ? COLS - 1 : COLS - CART_W;
    localparam logic [PW:0]     LIMIT_W = (PW + 1)'(LIMIT);
    localparam logic [PW-1:0]   START_P = PW'(START_POS);

    cart_state_t         state, state_nxt;
    logic [PW-1:0]       pos, pos_nxt;
    logic                req_l, req_r, req_l_nxt, req_r_nxt;
    logic                tick, mv_l, mv_r;
    logic [PW:0]         up, dn;
    logic [MAX_COLS-1:0] mask;

    tick_div #(.WIDTH(WIDTH)) u_div (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.gg),
        .en    (state == PLAY),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= PLAY;
            pos   <= START_P;
            req_l <= 1'b0;
            req_r <= 1'b0;
        end else begin
            state <= state_nxt;
            pos   <= pos_nxt;
            req_l <= req_l_nxt;
            req_r <= req_r_nxt;
        end
    end

    // One extra bit on up/dn so limit and underflow are visible before wrap or clamp.
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        req_l_nxt = req_l;
        req_r_nxt = req_r;
        mv_l      = req_l | bus.inL;
        mv_r      = req_r | bus.inR;
        up        = {1'b0, pos} + 1'b1;
        dn        = {1'b0, pos} - 1'b1;
        case (state)
            PLAY: begin
                if (bus.gg) begin
                    state_nxt = DEAD;
                    req_l_nxt = 1'b0;
                    req_r_nxt = 1'b0;
                end else if (tick) begin
                    req_l_nxt = 1'b0;
                    req_r_nxt = 1'b0;
                    if (mv_l && !mv_r) begin
                        if (up <= LIMIT_W)
                            pos_nxt = up[PW-1:0];
                        else if (WRAP != 0)
                            pos_nxt = '0;
                    end else if (mv_r && !mv_l) begin
                        if (!dn[PW])
                            pos_nxt = dn[PW-1:0];
                        else if (WRAP != 0)
                            pos_nxt = LIMIT_W[PW-1:0];
                    end
                end else begin
                    req_l_nxt = mv_l;
                    req_r_nxt = mv_r;
                end
            end
            default: begin
            end
        endcase
    end

    assign mask = cart_mask(int'(pos), COLS, CART_W, WRAP != 0);

    if (COLS < MAX_COLS) begin : g_pad
        logic [MAX_COLS-COLS-1:0] pad_unused;
        assign pad_unused = mask[MAX_COLS-1:COLS];
    end

    assign bus.out   = (state == PLAY) ? mask[COLS-1:0] : '0;
    assign bus.pos   = pos;
    assign bus.alive = (state == PLAY);

endmodule

// File: tb/tb_cart_row.sv
// Directed bench for cart_row: one wrap-around and one clamping instance share stimulus.
module tb_cart_row;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic inL   = 1'b0;
    logic inR   = 1'b0;
    logic gg    = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cart_row_if #(.COLS(8)) wif ();
    cart_row_if #(.COLS(8)) cif ();

    assign wif.inL = inL;
    assign wif.inR = inR;
    assign wif.gg  = gg;
    assign cif.inL = inL;
    assign cif.inR = inR;
    assign cif.gg  = gg;

    cart_row #(.COLS(8), .CART_W(2), .WIDTH(2), .WRAP(1), .START_POS(3)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (wif)
    );

    cart_row #(.COLS(8), .CART_W(2), .WIDTH(2), .WRAP(0), .START_POS(3)) u_clamp (
        .clk   (clk),
        .reset (reset),
        .bus   (cif)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        int t, e;

        // reset and idle
        do_reset();
        check("rst_pos",   int'(wif.pos),   3);
        check("rst_out",   int'(wif.out),   'h18);
        check("rst_alive", int'(wif.alive), 1);
        check("rst_c_out", int'(cif.out),   'h18);
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("idle_pos",   int'(wif.pos),   3);
            check("idle_out",   int'(wif.out),   'h18);
            check("idle_alive", int'(wif.alive), 1);
        end

        // hold inL: wrap instance steps 4,5,6,7,0,1; clamp instance stops at 6
        do_reset();
        inL = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            cyc();
            t = (n - 1) / 4 + 1;
            check("wrap_l_pos", int'(wif.pos), (3 + t) % 8);
            check("clamp_l_pos", int'(cif.pos), (3 + t > 6) ? 6 : 3 + t);
            if (n == 13) check("wrap_out7", int'(wif.out), 'h81);
            if (n == 17) check("wrap_out0", int'(wif.out), 'h03);
        end
        check("clamp_out6", int'(cif.out), 'hC0);

        // hold inR: the still-latched left request cancels the first tick
        inL = 1'b0;
        inR = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cyc();
            t = (k - 1) / 4 + 1;
            e = 6 - (t - 1);
            check("clamp_r_pos", int'(cif.pos), (e < 0) ? 0 : e);
        end
        check("clamp_out0", int'(cif.out), 'h03);
        inR = 1'b0;

        // single-cycle pulse at cnt=2 is latched until the next tick
        do_reset();
        cyc();
        cyc();
        inL = 1'b1;
        cyc();
        inL = 1'b0;
        check("pulse_hold3", int'(wif.pos), 3);
        cyc();
        check("pulse_hold4", int'(wif.pos), 3);
        cyc();
        check("pulse_pos", int'(wif.pos), 4);
        check("pulse_out", int'(wif.out), 'h30);
        inL = 1'b1;
        cyc();
        inL = 1'b0;
        inR = 1'b1;
        cyc();
        inR = 1'b0;
        cyc();
        cyc();
        check("lr_cancel", int'(wif.pos), 4);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("lr_after", int'(wif.pos), 4);
        end

        // simultaneous requests never move
        do_reset();
        inL = 1'b1;
        inR = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("both_pos", int'(wif.pos), 3);
        end
        inL = 1'b0;
        inR = 1'b0;

        // reset mid-window with a request latched
        do_reset();
        inL = 1'b1;
        cyc();
        cyc();
        inL = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_pos", int'(wif.pos), 3);
        cyc();
        check("mid_rst_tick", int'(wif.pos), 3);

        // game over, inputs ignored while dead, reset recovers
        do_reset();
        gg = 1'b1;
        cyc();
        gg = 1'b0;
        check("gg_out",     int'(wif.out),   0);
        check("gg_alive",   int'(wif.alive), 0);
        check("gg_pos",     int'(wif.pos),   3);
        check("gg_c_alive", int'(cif.alive), 0);
        for (int i = 0; i < 10; i++) begin
            inL = (i % 2 == 0);
            inR = (i % 2 != 0);
            gg  = (i == 4);
            cyc();
            check("dead_out",   int'(wif.out),   0);
            check("dead_alive", int'(wif.alive), 0);
            check("dead_pos",   int'(wif.pos),   3);
        end
        inL = 1'b0;
        inR = 1'b0;
        gg  = 1'b0;
        do_reset();
        check("revive_out",   int'(wif.out),   'h18);
        check("revive_alive", int'(wif.alive), 1);
        check("revive_pos",   int'(wif.pos),   3);
        reset = 1'b1;
        gg    = 1'b1;
        cyc();
        reset = 1'b0;
        gg    = 1'b0;
        check("rst_gg_alive", int'(wif.alive), 1);
        check("rst_gg_out",   int'(wif.out),   'h18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
